// File: rtl/dunc_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dunc_core_if : REQ/READY memory bus between dunc_core and memory      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface dunc_core_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12
);
   logic              MEM_REQ;
   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [WIDTH-1:0]  MEM_WDATA;
   logic [WIDTH-1:0]  MEM_RDATA;
   logic              MEM_READY;

   modport master (
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      input  MEM_RDATA, MEM_READY
   );

   modport slave (
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      output MEM_RDATA, MEM_READY
   );
endinterface
`default_nettype wire

// File: rtl/dunc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dunc_core : parametrised single-accumulator CPU, REQ/READY memory bus |
// | Option    : DUNC_CARRY_EN adds carry flag and JC (opcode 8)           |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module dunc_core #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12
) (
   input  logic              CLK,
   input  logic              RESET_N,
   dunc_core_if.master       bus,
   output logic [ADDR_W-1:0] PC_OUT,
   output logic [WIDTH-1:0]  AC_OUT,
   output logic [3:0]        IR_OUT,
   output logic              AZ,
   output logic              AN,
   output logic              CARRY,
   output logic              FETCH,
   output logic              HALTED
);
   localparam logic [3:0] c_OP_LDA = 4'h0;
   localparam logic [3:0] c_OP_STA = 4'h1;
   localparam logic [3:0] c_OP_ADD = 4'h2;
   localparam logic [3:0] c_OP_AND = 4'h3;
   localparam logic [3:0] c_OP_JMP = 4'h4;
   localparam logic [3:0] c_OP_JN  = 4'h5;
   localparam logic [3:0] c_OP_JZ  = 4'h6;
   localparam logic [3:0] c_OP_NOT = 4'h7;
   localparam logic [3:0] c_OP_HLT = 4'hF;
`ifdef DUNC_CARRY_EN
   localparam logic [3:0] c_OP_JC  = 4'h8;
`endif

   typedef enum logic [2:0] {
      S_F0   = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_E0   = 3'd3,
      S_E1   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_pc, r_ma;
   logic [WIDTH-1:0]  r_ac, r_md, w_add_res;
   logic [3:0]        r_ir;
   logic              w_az, w_an, w_carry;
   logic              w_req, w_we, w_ma_from_pc, w_load_md, w_inc_pc;
   logic              w_load_ir, w_load_pc, w_ac_not, w_exec;

   assign w_az = (r_ac == '0);
   assign w_an = r_ac[WIDTH-1];

`ifdef DUNC_CARRY_EN
   logic             r_carry;
   logic [WIDTH:0]   w_sum;
   assign w_sum     = {1'b0, r_ac} + {1'b0, r_md};
   assign w_add_res = w_sum[WIDTH-1:0];
   assign w_carry   = r_carry;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)                      r_carry <= 1'b0;
      else if (w_exec && r_ir == c_OP_ADD) r_carry <= w_sum[WIDTH];
   end
`else
   assign w_add_res = r_ac + r_md;
   assign w_carry   = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_F0;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_we         = 1'b0;
      w_ma_from_pc = 1'b0;
      w_load_md    = 1'b0;
      w_inc_pc     = 1'b0;
      w_load_ir    = 1'b0;
      w_load_pc    = 1'b0;
      w_ac_not     = 1'b0;
      w_exec       = 1'b0;
      case (r_state)
         S_F0: begin
            w_ma_from_pc = 1'b1;
            w_state_next = S_F1;
         end
         S_F1: begin
            w_req = 1'b1;
            if (bus.MEM_READY) begin
               w_load_md    = 1'b1;
               w_inc_pc     = 1'b1;
               w_state_next = S_F2;
            end
         end
         S_F2: begin
            w_load_ir    = 1'b1;
            w_state_next = S_E0;
         end
         S_E0: begin
            // Non-memory opcodes complete here; NOP and unused codes fall to default.
            w_state_next = S_F0;
            case (r_ir)
               c_OP_LDA, c_OP_ADD, c_OP_AND: begin
                  w_req        = 1'b1;
                  w_load_md    = bus.MEM_READY;
                  w_state_next = bus.MEM_READY ? S_E1 : S_E0;
               end
               c_OP_STA: begin
                  w_req        = 1'b1;
                  w_we         = 1'b1;
                  w_state_next = bus.MEM_READY ? S_F0 : S_E0;
               end
               c_OP_JMP: w_load_pc = 1'b1;
               c_OP_JN:  w_load_pc = w_an;
               c_OP_JZ:  w_load_pc = w_az;
`ifdef DUNC_CARRY_EN
               c_OP_JC:  w_load_pc = r_carry;
`endif
               c_OP_NOT: w_ac_not = 1'b1;
               c_OP_HLT: w_state_next = S_HALT;
               default:  ;
            endcase
         end
         S_E1: begin
            w_exec       = 1'b1;
            w_state_next = S_F0;
         end
         S_HALT:  w_state_next = S_HALT;
         default: w_state_next = S_F0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pc <= '0;
         r_ma <= '0;
         r_md <= '0;
         r_ac <= '0;
         r_ir <= '0;
      end else begin
         if (w_ma_from_pc)   r_ma <= r_pc;
         else if (w_load_ir) r_ma <= r_md[ADDR_W-1:0];
         if (w_load_md)      r_md <= bus.MEM_RDATA;
         if (w_load_ir)      r_ir <= r_md[WIDTH-1 -: 4];
         if (w_inc_pc)       r_pc <= r_pc + ADDR_W'(1);
         else if (w_load_pc) r_pc <= r_ma;
         if (w_ac_not) begin
            r_ac <= ~r_ac;
         end else if (w_exec) begin
            case (r_ir)
               c_OP_LDA: r_ac <= r_md;
               c_OP_ADD: r_ac <= w_add_res;
               c_OP_AND: r_ac <= r_ac & r_md;
               default:  ;
            endcase
         end
      end
   end

   assign bus.MEM_REQ   = w_req;
   assign bus.MEM_WE    = w_we;
   assign bus.MEM_ADDR  = r_ma;
   assign bus.MEM_WDATA = r_ac;

   assign PC_OUT = r_pc;
   assign AC_OUT = r_ac;
   assign IR_OUT = r_ir;
   assign AZ     = w_az;
   assign AN     = w_an;
   assign CARRY  = w_carry;
   assign FETCH  = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_F2);
   assign HALTED = (r_state == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_dunc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dunc_core : self-checking bench, instruction-level reference model |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_dunc_core;
`ifdef DUNC_CARRY_EN
   localparam bit c_CARRY_EN = 1'b1;
`else
   localparam bit c_CARRY_EN = 1'b0;
`endif

   logic        CLK;
   logic        RESET_N;
   logic [11:0] PC_OUT;
   logic [15:0] AC_OUT;
   logic [3:0]  IR_OUT;
   logic        AZ, AN, CARRY, FETCH, HALTED;
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   logic [11:0] ref_pc;
   logic [15:0] ref_ac;
   logic        ref_cy;
   logic        ref_halt;

   dunc_core_if #(.WIDTH(16), .ADDR_W(12)) bus ();

   dunc_core #(.WIDTH(16), .ADDR_W(12)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus.master),
      .PC_OUT  (PC_OUT),
      .AC_OUT  (AC_OUT),
      .IR_OUT  (IR_OUT),
      .AZ      (AZ),
      .AN      (AN),
      .CARRY   (CARRY),
      .FETCH   (FETCH),
      .HALTED  (HALTED)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model: combinational read, write on the completing edge
   assign bus.MEM_RDATA = mem[bus.MEM_ADDR];
   always @(posedge CLK) begin
      if (bus.MEM_REQ && bus.MEM_READY && bus.MEM_WE) mem[bus.MEM_ADDR] = bus.MEM_WDATA;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   task automatic start();
      bus.MEM_READY = 1'b1;
      @(posedge CLK); #1;
      RESET_N = 1'b1;
   endtask

   task automatic ref_init();
      for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
      ref_pc = '0; ref_ac = '0; ref_cy = 1'b0; ref_halt = 1'b0;
   endtask

   // One instruction at architectural level; returns its zero-wait cycle count
   task automatic ref_step(output int cycles);
      logic [15:0] w;
      logic [11:0] a;
      logic [16:0] s;
      w = ref_mem[ref_pc];
      a = w[11:0];
      ref_pc = ref_pc + 12'd1;
      cycles = 4;
      case (w[15:12])
         4'h0: begin ref_ac = ref_mem[a]; cycles = 5; end
         4'h1: ref_mem[a] = ref_ac;
         4'h2: begin
            s = {1'b0, ref_ac} + {1'b0, ref_mem[a]};
            ref_ac = s[15:0];
            if (c_CARRY_EN) ref_cy = s[16];
            cycles = 5;
         end
         4'h3: begin ref_ac = ref_ac & ref_mem[a]; cycles = 5; end
         4'h4: ref_pc = a;
         4'h5: if (ref_ac[15]) ref_pc = a;
         4'h6: if (ref_ac == 16'h0) ref_pc = a;
         4'h7: ref_ac = ~ref_ac;
         4'h8: if (c_CARRY_EN && ref_cy) ref_pc = a;
         4'hF: ref_halt = 1'b1;
         default: ;
      endcase
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h0010; mem[1] = 16'h2011; mem[16'h10] = 16'h7FFF; mem[16'h11] = 16'h0001;
      start();
      repeat (6) @(posedge CLK);
      #1 bus.MEM_READY = 1'b0;
      @(posedge CLK); #1;
      n_checks++;
      if ((bus.MEM_REQ && FETCH) !== 1'b1) begin n_fail++; $display("FAIL reset_pre_f1: req=%b fetch=%b expected 1 1", bus.MEM_REQ, FETCH); end
      n_checks++;
      if (AC_OUT !== 16'h7FFF) begin n_fail++; $display("FAIL reset_pre_ac: got %h expected 7fff", AC_OUT); end
      #2 RESET_N = 1'b0;
      #1;
      n_checks++;
      if (bus.MEM_REQ !== 1'b0 || bus.MEM_WE !== 1'b0) begin n_fail++; $display("FAIL reset_req: req=%b we=%b expected 0 0", bus.MEM_REQ, bus.MEM_WE); end
      n_checks++;
      if (PC_OUT !== 12'h000 || AC_OUT !== 16'h0000) begin n_fail++; $display("FAIL reset_regs: pc=%h ac=%h expected 000 0000", PC_OUT, AC_OUT); end
      n_checks++;
      if ({AZ, AN, CARRY, FETCH, HALTED} !== 5'b10010) begin n_fail++; $display("FAIL reset_flags: az/an/cy/fetch/halt=%b expected 10010", {AZ, AN, CARRY, FETCH, HALTED}); end
      n_checks++;
      if (IR_OUT !== 4'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected 0", IR_OUT); end
   endtask

   task automatic test_program();
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'hF000;
      mem[16'h10] = 16'h7FFF; mem[16'h11] = 16'h0001;
      start();
      repeat (17) @(posedge CLK);
      #1;
      n_checks++;
      if (HALTED !== 1'b0) begin n_fail++; $display("FAIL prog_halt17: halted=%b expected 0", HALTED); end
      @(posedge CLK); #1;
      n_checks++;
      if (HALTED !== 1'b1 || FETCH !== 1'b0) begin n_fail++; $display("FAIL prog_halt18: halted=%b fetch=%b expected 1 0", HALTED, FETCH); end
      n_checks++;
      if (mem[16'h12] !== 16'h8000) begin n_fail++; $display("FAIL prog_store: got %h expected 8000", mem[16'h12]); end
      n_checks++;
      if (AN !== 1'b1 || AC_OUT !== 16'h8000) begin n_fail++; $display("FAIL prog_ac: an=%b ac=%h expected 1 8000", AN, AC_OUT); end
      n_checks++;
      if (PC_OUT !== 12'h004) begin n_fail++; $display("FAIL prog_pc: got %h expected 004", PC_OUT); end
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if (HALTED !== 1'b1 || bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL prog_halt_hold: halted=%b req=%b expected 1 0", HALTED, bus.MEM_REQ); end
   endtask

   task automatic test_conditionals();
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h5020; mem[1] = 16'h6020; mem[16'h20] = 16'hF000;
      start();
      repeat (4) @(posedge CLK);
      #1;
      n_checks++;
      if (PC_OUT !== 12'h001) begin n_fail++; $display("FAIL cond_jn: pc=%h expected 001", PC_OUT); end
      repeat (4) @(posedge CLK);
      #1;
      n_checks++;
      if (PC_OUT !== 12'h020) begin n_fail++; $display("FAIL cond_jz: pc=%h expected 020", PC_OUT); end
   endtask

   task automatic test_wait_states();
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h9000; mem[1] = 16'hF000;
      start();
      bus.MEM_READY = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge CLK); #1;
         n_checks++;
         if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, PC_OUT} !== {1'b1, 1'b0, 12'h000, 12'h000}) begin
            n_fail++;
            $display("FAIL wait_stall%0d: req=%b we=%b addr=%h pc=%h expected 1 0 000 000", k, bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, PC_OUT);
         end
      end
      bus.MEM_READY = 1'b1;
      @(posedge CLK); #1;
      n_checks++;
      if (PC_OUT !== 12'h001) begin n_fail++; $display("FAIL wait_pc_inc: pc=%h expected 001", PC_OUT); end
      @(posedge CLK); #1;
      n_checks++;
      if (FETCH !== 1'b0) begin n_fail++; $display("FAIL wait_e0: fetch=%b expected 0", FETCH); end
      @(posedge CLK); #1;
      n_checks++;
      if (FETCH !== 1'b1 || bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL wait_7cyc: fetch=%b req=%b expected 1 0", FETCH, bus.MEM_REQ); end
   endtask

   task automatic test_wrap();
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h9000;
      start();
      repeat (4) @(posedge CLK);
      #1;
      n_checks++;
      if (PC_OUT !== 12'hFFF) begin n_fail++; $display("FAIL wrap_jmp: pc=%h expected fff", PC_OUT); end
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if (PC_OUT !== 12'h000) begin n_fail++; $display("FAIL wrap_pc: pc=%h expected 000", PC_OUT); end
   endtask

   task automatic test_carry();
      logic [11:0] exp_pc;
      RESET_N = 1'b0;
      clear_mem();
      mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h8040; mem[3] = 16'hF000;
      mem[16'h10] = 16'hFFFF; mem[16'h11] = 16'h0001; mem[16'h40] = 16'hF000;
      exp_pc = c_CARRY_EN ? 12'h040 : 12'h003;
      start();
      repeat (10) @(posedge CLK);
      #1;
      n_checks++;
      if (AC_OUT !== 16'h0000 || AZ !== 1'b1) begin n_fail++; $display("FAIL carry_ac: ac=%h az=%b expected 0000 1", AC_OUT, AZ); end
      n_checks++;
      if (CARRY !== c_CARRY_EN) begin n_fail++; $display("FAIL carry_flag: got %b expected %b", CARRY, c_CARRY_EN); end
      repeat (4) @(posedge CLK);
      #1;
      n_checks++;
      if (PC_OUT !== exp_pc) begin n_fail++; $display("FAIL carry_jc: pc=%h expected %h", PC_OUT, exp_pc); end
   endtask

   task automatic test_random_lockstep();
      int          op, cyc;
      logic [11:0] a;
      RESET_N = 1'b0;
      clear_mem();
      for (int i = 0; i < 64; i++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 3)                             a = 12'h100 + 12'($urandom_range(0, 15));
         else if (op == 4 || op == 5 || op == 6 || op == 8) a = 12'($urandom_range(0, 63));
         else                                     a = 12'($urandom);
         mem[i] = {4'(op), a};
      end
      mem[64] = 16'hF000;
      for (int i = 0; i < 16; i++) mem[12'h100 + i] = (i < 2) ? 16'h0000 : 16'($urandom);
      ref_init();
      start();
      for (int k = 0; k < 200 && !ref_halt; k++) begin
         ref_step(cyc);
         repeat (cyc) @(posedge CLK);
         #1;
         n_checks++;
         if ({PC_OUT, AC_OUT, CARRY, HALTED} !== {ref_pc, ref_ac, ref_cy, ref_halt}) begin
            n_fail++;
            $display("FAIL lockstep_%0d: pc=%h ac=%h cy=%b halt=%b expected %h %h %b %b", k, PC_OUT, AC_OUT, CARRY, HALTED, ref_pc, ref_ac, ref_cy, ref_halt);
         end
         n_checks++;
         if ({AZ, AN} !== {ref_ac == 16'h0, ref_ac[15]}) begin
            n_fail++;
            $display("FAIL lockstep_flags_%0d: az/an=%b%b expected %b%b", k, AZ, AN, ref_ac == 16'h0, ref_ac[15]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (mem[12'h100 + i] !== ref_mem[12'h100 + i]) begin
            n_fail++;
            $display("FAIL lockstep_mem_%0d: got %h expected %h", i, mem[12'h100 + i], ref_mem[12'h100 + i]);
         end
      end
   endtask

   task automatic test_random_ready();
      int          ops [6] = '{0, 1, 2, 3, 7, 9};
      int          op, cyc;
      bit          done;
      logic        p_req, p_we, p_rdy;
      logic [11:0] p_addr;
      logic [15:0] p_wd;
      RESET_N = 1'b0;
      clear_mem();
      for (int i = 0; i < 30; i++) begin
         op = ops[$urandom_range(0, 5)];
         mem[i] = {4'(op), 12'h200 + 12'($urandom_range(0, 7))};
      end
      mem[30] = 16'hF000;
      for (int i = 0; i < 8; i++) mem[12'h200 + i] = 16'($urandom);
      ref_init();
      for (int k = 0; k < 100 && !ref_halt; k++) ref_step(cyc);
      start();
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         bus.MEM_READY = 1'($urandom_range(0, 1));
         p_req = bus.MEM_REQ; p_we = bus.MEM_WE; p_addr = bus.MEM_ADDR; p_wd = bus.MEM_WDATA; p_rdy = bus.MEM_READY;
         @(posedge CLK); #1;
         if (p_req && !p_rdy) begin
            n_checks++;
            if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA} !== {1'b1, p_we, p_addr, p_wd}) begin
               n_fail++;
               $display("FAIL stall_hold_t%0d: req=%b we=%b addr=%h wd=%h expected 1 %b %h %h", t, bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, p_we, p_addr, p_wd);
            end
         end
         done = HALTED;
      end
      bus.MEM_READY = 1'b1;
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL rr_timeout: halted=%b expected 1", HALTED); end
      n_checks++;
      if (PC_OUT !== ref_pc || AC_OUT !== ref_ac) begin n_fail++; $display("FAIL rr_final: pc=%h ac=%h expected %h %h", PC_OUT, AC_OUT, ref_pc, ref_ac); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (mem[12'h200 + i] !== ref_mem[12'h200 + i]) begin
            n_fail++;
            $display("FAIL rr_mem_%0d: got %h expected %h", i, mem[12'h200 + i], ref_mem[12'h200 + i]);
         end
      end
   endtask

   initial begin
      RESET_N       = 1'b0;
      bus.MEM_READY = 1'b1;
      test_reset();
      test_program();
      test_conditionals();
      test_wait_states();
      test_wrap();
      test_carry();
      test_random_lockstep();
      test_random_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
